// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   tx_state_t   : transmit FSM states, also exported on the debug state port
//   MAX_DATA_BITS: widest supported data field
//   calc_parity  : parity bit over a zero-extended data word (used by TX and RX)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MAX_DATA_BITS = 9;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular-buffer synchronous FIFO for the UART transmit path.
//   Clk, Rst      : clock, asynchronous active-high reset (pointers and count)
//   push, wr_data : write request and data; ignored when full unless popping too
//   pop, rd_data  : read request; rd_data always shows the head entry
//   empty, full   : decoded from the registered count
//   count         : number of stored entries (one bit wider than the pointers)
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // A simultaneous pop frees the slot the push needs, so a full FIFO may
  // still accept a write in that cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO plus frame serializer.
//   Clk, Rst      : clock, asynchronous active-high reset (aborts any frame)
//   Tx_Data/Tx_Wr : host write port, one-cycle strobe
//   Ovf_Clr       : clears the sticky FIFO_Overflow flag (a same-cycle set wins)
//   BIST_Mode     : host writes ignored; queued data still drains
//   Tx            : registered serial line, idle high
//   Tx_Busy       : a frame is on the line
//   Tx_Done       : high in the final cycle of the last stop bit
//   FIFO_Empty/FIFO_Full/FIFO_Overflow : FIFO status
//   Dbg_State     : current FSM state
//
// Write handshake: Tx_Wr acts as a valid with no ready. The host is expected
// to watch FIFO_Full; a write seen while full (and with no pop in the same
// cycle) is dropped and recorded in FIFO_Overflow instead of stalling.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_Wr,
  input  logic                 Ovf_Clr,
  input  logic                 BIST_Mode,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 Tx_Done,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output tx_state_t            Dbg_State
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  tx_state_t            state_q, state_n;
  logic [BAUD_W-1:0]    baud_q, baud_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 ovf_q;

  logic                 pop;
  logic                 push;
  logic                 wr_req;
  logic                 ovf_set;
  logic                 bit_end;

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;

  tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .push    (push),
    .pop     (pop),
    .wr_data (Tx_Data),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign wr_req  = Tx_Wr && !BIST_Mode;
  assign push    = wr_req && (!fifo_full || pop);
  assign ovf_set = wr_req && fifo_full && !pop;
  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state, counters, shift register and the pop request.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rd_data;
          par_n   = calc_parity(MAX_DATA_BITS'(fifo_rd_data), PAR_ODD);
          state_n = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_q == STOP_LAST) begin
            bit_n = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = fifo_rd_data;
              par_n   = calc_parity(MAX_DATA_BITS'(fifo_rd_data), PAR_ODD);
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Line level for the next cycle, taken from where the FSM is heading so
  // the registered Tx lines up exactly with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (Ovf_Clr) ovf_q <= 1'b0;
    end
  end

  assign Tx            = tx_q;
  assign Tx_Busy       = (state_q != IDLE);
  assign Tx_Done       = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
  assign FIFO_Empty    = fifo_empty;
  assign FIFO_Full     = (fifo_count == FULL_CNT);
  assign FIFO_Overflow = ovf_q;
  assign Dbg_State     = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Two instances share one stimulus stream:
//   dut_a: even parity, one stop bit
//   dut_b: no parity, two stop bits
// Both frames are 11 bits x 4 clocks = 44 clocks, so FIFO/flag timing is
// identical and only the line contents differ.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 11 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_wr   = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       bist    = 1'b0;

  logic tx_a, busy_a, done_a, empty_a, full_a, ovf_a;
  logic tx_b, busy_b, done_b, empty_b, full_b, ovf_b;
  tx_state_t st_a, st_b;

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
            .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .Clk(clk), .Rst(rst), .Tx_Data(tx_data), .Tx_Wr(tx_wr), .Ovf_Clr(ovf_clr),
    .BIST_Mode(bist), .Tx(tx_a), .Tx_Busy(busy_a), .Tx_Done(done_a),
    .FIFO_Empty(empty_a), .FIFO_Full(full_a), .FIFO_Overflow(ovf_a),
    .Dbg_State(st_a));

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
    .Clk(clk), .Rst(rst), .Tx_Data(tx_data), .Tx_Wr(tx_wr), .Ovf_Clr(ovf_clr),
    .BIST_Mode(bist), .Tx(tx_b), .Tx_Busy(busy_b), .Tx_Done(done_b),
    .FIFO_Empty(empty_b), .FIFO_Full(full_b), .FIFO_Overflow(ovf_b),
    .Dbg_State(st_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [7:0] exp_q[$];   // bytes waiting in the transmit queue
  bit         m_act;      // a frame is on the line
  int         m_pos;      // clock index within the current frame
  logic [7:0] m_cur;      // byte being sent
  bit         m_ovf;

  // Bit idx of a frame: 0 start, 1..8 data LSB first, 9 parity or 2nd stop, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int idx, input bit with_par);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return with_par ? ^d : 1'b1;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : sb
    bit wr, pop, set_ovf;
    int had;
    if (rst) begin
      exp_q.delete();
      m_act = 0; m_pos = 0; m_cur = '0; m_ovf = 0;
    end else begin
      wr      = tx_wr && !bist;
      had     = exp_q.size();
      pop     = (had != 0) && (!m_act || m_pos == FRAME - 1);
      set_ovf = 0;
      if (m_act && m_pos != FRAME - 1) m_pos++;
      else if (pop) begin m_cur = exp_q.pop_front(); m_act = 1; m_pos = 0; end
      else m_act = 0;
      if (wr) begin
        if (had < DEPTH || pop) exp_q.push_back(tx_data);
        else set_ovf = 1;
      end
      if (set_ovf) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
    #1;
    check("sb_tx_a",    tx_a,    m_act ? frame_bit(m_cur, m_pos / CPB, 1) : 1'b1);
    check("sb_tx_b",    tx_b,    m_act ? frame_bit(m_cur, m_pos / CPB, 0) : 1'b1);
    check("sb_busy_a",  busy_a,  m_act);
    check("sb_busy_b",  busy_b,  m_act);
    check("sb_done_a",  done_a,  m_act && m_pos == FRAME - 1);
    check("sb_done_b",  done_b,  m_act && m_pos == FRAME - 1);
    check("sb_empty_a", empty_a, exp_q.size() == 0);
    check("sb_empty_b", empty_b, exp_q.size() == 0);
    check("sb_full_a",  full_a,  exp_q.size() == DEPTH);
    check("sb_full_b",  full_b,  exp_q.size() == DEPTH);
    check("sb_ovf_a",   ovf_a,   m_ovf);
    check("sb_ovf_b",   ovf_b,   m_ovf);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [FRAME-1:0] expand(input logic [10:0] bits);
    logic [FRAME-1:0] r;
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < CPB; j++)
        r[FRAME-1-(i*CPB+j)] = bits[10-i];
    return r;
  endfunction

  task automatic write_one(input logic [7:0] d);
    @(negedge clk); tx_wr = 1'b1; tx_data = d;
    @(negedge clk); tx_wr = 1'b0;
  endtask

  // First sample taken at the current negedge; first line cycle goes to the MSB.
  task automatic capture(output logic [FRAME-1:0] la, output logic [FRAME-1:0] lb,
                         output int nda, output int ndb);
    nda = 0; ndb = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      la[FRAME-1-i] = tx_a;
      lb[FRAME-1-i] = tx_b;
      nda += int'(done_a);
      ndb += int'(done_b);
    end
  endtask

  task automatic wait_idle(input int budget, output int ndone);
    int n = 0;
    ndone = 0;
    while (!(busy_a == 1'b0 && empty_a == 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
      ndone += int'(done_a);
    end
    check("wait_idle_in_budget", n < budget, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_in_budget", n < budget, 1'b1);
  endtask

  logic [FRAME-1:0] la, lb;
  int da, db, nd;

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_empty", empty_a, 1'b1);
    check("rst_full", full_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    rst = 1'b0;

    // 0xA5 from idle
    write_one(8'hA5);
    check("a5_empty_after_wr", empty_a, 1'b0);
    check("a5_tx_high_after_wr", tx_a, 1'b1);
    @(negedge clk);
    check("a5_start_at_2clk", tx_a, 1'b0);
    check("a5_empty_after_pop", empty_a, 1'b1);
    capture(la, lb, da, db);
    check("a5_line_a", la, expand(11'b01010010101));
    check("a5_line_b", lb, expand(11'b01010010111));
    check("a5_done_count_a", da, 1);
    check("a5_done_count_b", db, 1);
    check("a5_done_last", done_a, 1'b1);
    @(negedge clk);
    check("a5_busy_after", busy_a, 1'b0);
    check("a5_done_after", done_a, 1'b0);

    // overflow: 0x01..0x06 on consecutive cycles
    @(negedge clk); tx_wr = 1'b1; tx_data = 8'h01;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check("ovf_full_after_5", full_a, 1'b1);
        check("ovf_clear_before_6", ovf_a, 1'b0);
      end
      tx_data = 8'(k);
    end
    @(negedge clk); tx_wr = 1'b0;
    check("ovf_set_a", ovf_a, 1'b1);
    check("ovf_set_b", ovf_b, 1'b1);
    check("ovf_full_kept", full_a, 1'b1);
    wait_idle(5 * FRAME + 20, nd);
    check("ovf_frames_sent", nd, 5);
    check("ovf_sticky", ovf_a, 1'b1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_cleared_a", ovf_a, 1'b0);
    check("ovf_cleared_b", ovf_b, 1'b0);

    // full FIFO, write coinciding with end-of-stop pop
    @(negedge clk); tx_wr = 1'b1; tx_data = 8'h11;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk); tx_data = 8'h11 + 8'(k);
    end
    @(negedge clk); tx_wr = 1'b0;
    check("fp_full", full_a, 1'b1);
    wait_done(FRAME + 10);
    tx_wr = 1'b1; tx_data = 8'h16;
    @(negedge clk); tx_wr = 1'b0;
    check("fp_still_full", full_a, 1'b1);
    check("fp_no_ovf", ovf_a, 1'b0);
    check("fp_busy", busy_a, 1'b1);
    wait_idle(5 * FRAME + 20, nd);
    check("fp_frames_sent", nd, 5);
    check("fp_no_ovf_end", ovf_a, 1'b0);

    // BIST mode ignores writes
    @(negedge clk); bist = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_data = 8'hF0 + 8'(i);
      @(negedge clk);
      check("bist_tx", tx_a, 1'b1);
      check("bist_empty", empty_a, 1'b1);
      check("bist_ovf", ovf_a, 1'b0);
    end
    tx_wr = 1'b0; bist = 1'b0;

    // reset mid-DATA of 0x3C with two entries queued
    @(negedge clk); tx_wr = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'h77;
    @(negedge clk); tx_data = 8'h88;
    @(negedge clk); tx_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("rm_in_data", st_a, DATA);
    check("rm_tx_low_before", tx_a, 1'b0);
    check("rm_queued", empty_a, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rm_tx_a_async", tx_a, 1'b1);
    check("rm_tx_b_async", tx_b, 1'b1);
    check("rm_busy_async", busy_a, 1'b0);
    check("rm_empty_async", empty_a, 1'b1);
    check("rm_full_async", full_a, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    write_one(8'h55);
    @(negedge clk);
    capture(la, lb, da, db);
    check("rm_55_line_a", la, expand(11'b01010101001));
    check("rm_55_line_b", lb, expand(11'b01010101011));
    check("rm_55_done", da, 1);
    @(negedge clk);

    // 0x00: no-parity/two-stop frame is nine zeros then two ones
    write_one(8'h00);
    @(negedge clk);
    capture(la, lb, da, db);
    check("z_line_a", la, expand(11'b00000000001));
    check("z_line_b", lb, expand(11'b00000000011));
    check("z_done_b", db, 1);
    @(negedge clk);
    check("z_busy_b_after", busy_b, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
